// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator call scheduler.
//   - state_t : controller states
//   - dir_t   : travel direction memory (none / up / down)
//   - FC_*    : fault code values reported on fault_code
//   - N_FLOORS_DEF : default floor count (width of call/sensor vectors)
package elevador_pkg;

    localparam int N_FLOORS_DEF = 3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_HOMING,
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_MULTI   = 2'd1;
    localparam logic [1:0] FC_SEQ     = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage

// File: rtl/elev_target_select.sv
// Combinational next-direction pick for the collective policy.
// Ports:
//   pending   in  latched requests, bit i = floor i+1
//   cur_floor in  current floor 1..N
//   last_dir  in  direction of the previous departure (dir_t encoding)
//   req_valid out some request exists above or below the current floor
//   go_up     out 1 = depart upwards, 0 = depart downwards
// The last direction is kept while requests remain on that side; otherwise
// the nearest request wins and an equal distance resolves downwards.
module elev_target_select
    import elevador_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [1:0]          cur_floor,
    input  logic [1:0]          last_dir,
    output logic                req_valid,
    output logic                go_up
);

    int                  cur_idx;
    logic [N_FLOORS-1:0] above;
    logic [N_FLOORS-1:0] below;
    int                  near_up;
    int                  near_dn;

    assign cur_idx = int'(cur_floor) - 1;

    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_side
        assign above[gi] = pending[gi] && (gi > cur_idx);
        assign below[gi] = pending[gi] && (gi < cur_idx);
    end

    always_comb begin
        near_up = N_FLOORS;
        near_dn = N_FLOORS;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (above[i] && ((i - cur_idx) < near_up)) near_up = i - cur_idx;
            if (below[i] && ((cur_idx - i) < near_dn)) near_dn = cur_idx - i;
        end
        req_valid = (|above) || (|below);
        if ((last_dir == DIR_UP) && (|above)) begin
            go_up = 1'b1;
        end else if ((last_dir == DIR_DOWN) && (|below)) begin
            go_up = 1'b0;
        end else if ((|below) && (near_dn <= near_up)) begin
            go_up = 1'b0;
        end else begin
            go_up = |above;
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator sequencing controller: latches calls, chooses direction, drives
// motor and door commands, and supervises the floor/overweight sensors.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   call[N]           call buttons, bit i = floor i+1 (level)
//   floor_sns[N]      floor sensors, bit i high while cabin at floor i+1
//   overweight        inhibits departure and holds the door open
//   mup, mdw          motor up/down commands (registered)
//   door_open         door command (registered)
//   cur_floor[2]      last valid floor 1..3, 0 = unknown
//   pending[N]        latched request vector
//   fault, fault_code sticky fault flag and cause (1 multi, 2 sequence, 3 timeout)
// Build option: define ELEV_TRAVEL_TIMEOUT_EN to fault (code 3) when the cabin
// is commanded to move for TIMEOUT_CYCLES cycles without a new sensor edge.
module elevator_call_scheduler
    import elevador_pkg::*;
#(
    parameter int N_FLOORS       = N_FLOORS_DEF,
    parameter int DOOR_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call,
    input  logic [N_FLOORS-1:0] floor_sns,
    input  logic                overweight,
    output logic                mup,
    output logic                mdw,
    output logic                door_open,
    output logic [1:0]          cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam int CW = $clog2(DOOR_CYCLES + 1);

    state_t              state_reg;
    dir_t                last_dir_reg;
    logic [N_FLOORS-1:0] sns_prev_reg;
    logic [CW-1:0]       door_cnt_reg;

    logic [N_FLOORS-1:0] edge_v;
    logic [N_FLOORS-1:0] cur_onehot;
    logic [N_FLOORS-1:0] exp_up;
    logic [N_FLOORS-1:0] exp_dn;
    logic [N_FLOORS-1:0] latch_mask;
    logic [1:0]          sns_floor;
    logic [1:0]          edge_floor;
    logic                multi;
    logic                fault_det;
    logic [1:0]          fault_det_code;
    logic                req_valid;
    logic                go_up;

    // Rising sensor edges against the previous-cycle sample.
    assign edge_v = floor_sns & ~sns_prev_reg;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi  = |(floor_sns & (floor_sns - N_FLOORS'(1)));

    // Per-floor masks: current floor, and the only legal arrival floor
    // when travelling up (cur+1) or down (cur-1).
    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor
        assign cur_onehot[gi] = (int'(cur_floor) == gi + 1);
        assign exp_up[gi]     = (int'(cur_floor) == gi);
        assign exp_dn[gi]     = (int'(cur_floor) == gi + 2);
    end

    // A call for the floor whose door is open only restarts the door timer.
    assign latch_mask = (state_reg == ST_DOOR) ? (call & ~cur_onehot) : call;

    always_comb begin
        sns_floor  = '0;
        edge_floor = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (floor_sns[i]) sns_floor = 2'(i + 1);
            if (edge_v[i])    edge_floor = 2'(i + 1);
        end
    end

`ifdef ELEV_TRAVEL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_reg;
    logic          travelling;
    logic          tmo_hit;

    assign travelling = state_reg inside {ST_HOMING, ST_MOVE_UP, ST_MOVE_DOWN};
    assign tmo_hit    = travelling && (edge_v == '0) &&
                        (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
        end else if (travelling && (edge_v == '0)) begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end else begin
            tmo_cnt_reg <= '0;
        end
    end
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        fault_det      = 1'b0;
        fault_det_code = FC_NONE;
        if ((state_reg != ST_INIT) && (state_reg != ST_FAULT)) begin
            if (multi) begin
                fault_det      = 1'b1;
                fault_det_code = FC_MULTI;
            end else if ((state_reg == ST_MOVE_UP) && (|(edge_v & ~exp_up))) begin
                fault_det      = 1'b1;
                fault_det_code = FC_SEQ;
            end else if ((state_reg == ST_MOVE_DOWN) && (|(edge_v & ~exp_dn))) begin
                fault_det      = 1'b1;
                fault_det_code = FC_SEQ;
            end else if (((state_reg == ST_IDLE) || (state_reg == ST_DOOR)) &&
                         (|(edge_v & ~cur_onehot))) begin
                fault_det      = 1'b1;
                fault_det_code = FC_SEQ;
`ifdef ELEV_TRAVEL_TIMEOUT_EN
            end else if (tmo_hit) begin
                fault_det      = 1'b1;
                fault_det_code = FC_TIMEOUT;
`endif
            end
        end
    end

    elev_target_select #(
        .N_FLOORS (N_FLOORS)
    ) u_target (
        .pending   (pending),
        .cur_floor (cur_floor),
        .last_dir  (last_dir_reg),
        .req_valid (req_valid),
        .go_up     (go_up)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            last_dir_reg <= DIR_NONE;
            sns_prev_reg <= '0;
            door_cnt_reg <= '0;
            mup          <= 1'b0;
            mdw          <= 1'b0;
            door_open    <= 1'b0;
            cur_floor    <= '0;
            pending      <= '0;
            fault        <= 1'b0;
            fault_code   <= FC_NONE;
        end else begin
            sns_prev_reg <= floor_sns;
            // Lowest-precedence action; serve and fault override it below.
            if (state_reg != ST_FAULT) pending <= pending | latch_mask;

            if (fault_det || ((state_reg == ST_INIT) && multi)) begin
                state_reg  <= ST_FAULT;
                fault      <= 1'b1;
                fault_code <= fault_det ? fault_det_code : FC_MULTI;
                mup        <= 1'b0;
                mdw        <= 1'b0;
                door_open  <= 1'b0;
                pending    <= '0;
            end else begin
                case (state_reg)
                    ST_INIT: begin
                        if (floor_sns != '0) begin
                            cur_floor <= sns_floor;
                            state_reg <= ST_IDLE;
                        end else begin
                            mdw       <= 1'b1;
                            state_reg <= ST_HOMING;
                        end
                    end
                    ST_HOMING: begin
                        if (edge_v != '0) begin
                            cur_floor <= edge_floor;
                            mdw       <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (|(pending & cur_onehot)) begin
                            pending      <= (pending | latch_mask) & ~cur_onehot;
                            door_open    <= 1'b1;
                            door_cnt_reg <= CW'(DOOR_CYCLES - 1);
                            state_reg    <= ST_DOOR;
                        end else if (req_valid && !overweight) begin
                            if (go_up) begin
                                mup          <= 1'b1;
                                last_dir_reg <= DIR_UP;
                                state_reg    <= ST_MOVE_UP;
                            end else begin
                                mdw          <= 1'b1;
                                last_dir_reg <= DIR_DOWN;
                                state_reg    <= ST_MOVE_DOWN;
                            end
                        end
                    end
                    ST_MOVE_UP, ST_MOVE_DOWN: begin
                        // Any edge reaching here is the legal next floor.
                        if (edge_v != '0) begin
                            cur_floor <= edge_floor;
                            if (|(edge_v & pending)) begin
                                pending      <= (pending | latch_mask) & ~edge_v;
                                mup          <= 1'b0;
                                mdw          <= 1'b0;
                                door_open    <= 1'b1;
                                door_cnt_reg <= CW'(DOOR_CYCLES - 1);
                                state_reg    <= ST_DOOR;
                            end
                        end
                    end
                    ST_DOOR: begin
                        if (overweight || (|(call & cur_onehot))) begin
                            door_cnt_reg <= CW'(DOOR_CYCLES - 1);
                        end else if (door_cnt_reg == '0) begin
                            door_open <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            door_cnt_reg <= door_cnt_reg - CW'(1);
                        end
                    end
                    default: begin
                        // ST_FAULT: hold everything until reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed scenarios, then
// random call sets served by a simple cabin plant and compared against a
// floor-order reference model of the collective policy.
module tb_elevator_call_scheduler;

    localparam int SEG    = 4;          // plant steps between adjacent floors
    localparam int MAXPOS = 2 * SEG;

    logic       clk;
    logic       reset;
    logic [2:0] call;
    logic [2:0] floor_sns;
    logic       overweight;
    logic       mup;
    logic       mdw;
    logic       door_open;
    logic [1:0] cur_floor;
    logic [2:0] pending;
    logic       fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    bit plant_en = 0;
    int served_q[$];
    int exp_q[$];
    int mdl_floor;
    int mdl_dir;                         // 0 none, 1 up, 2 down

    elevator_call_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .call       (call),
        .floor_sns  (floor_sns),
        .overweight (overweight),
        .mup        (mup),
        .mdw        (mdw),
        .door_open  (door_open),
        .cur_floor  (cur_floor),
        .pending    (pending),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cabin plant: moves one step per cycle on the motor command, sensor
    // high only when exactly aligned with a floor.
    task automatic plant_step();
        if (mup && !mdw && pos < MAXPOS) pos++;
        else if (mdw && !mup && pos > 0) pos--;
        floor_sns = (pos % SEG == 0) ? (3'b001 << (pos / SEG)) : 3'b000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (plant_en) plant_step();
        chk("motor_exclusive", 32'(mup & mdw), 0);
        chk("door_motor_off", 32'(door_open & (mup | mdw)), 0);
    endtask

    task automatic do_reset(input logic [2:0] sns, input logic ow, input logic [2:0] c);
        call       = c;
        overweight = ow;
        floor_sns  = sns;
        reset      = 1'b1;
        #2;
        chk("reset_outputs", 32'({mup, mdw, door_open, cur_floor, pending, fault, fault_code}), 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_mup();
        int k;
        k = 0;
        while (!mup && k < 10) begin
            tick();
            k++;
        end
        chk("motor_up_start", 32'(mup), 1);
    endtask

    // Run until all requests are served; record the floor of every door
    // opening (taken from the plant position). Optionally inject one more
    // call the first time the cabin is seen moving up.
    task automatic collect(input logic [2:0] late);
        bit   door_prev;
        bit   done;
        logic [2:0] late_v;
        late_v = late;
        served_q.delete();
        door_prev = door_open;
        done = 0;
        for (int k = 0; k < 3000; k++) begin
            if (late_v != 3'b000 && mup) begin
                call   = late_v;
                late_v = 3'b000;
            end else begin
                call = 3'b000;
            end
            tick();
            if (door_open && !door_prev) begin
                served_q.push_back(pos / SEG + 1);
                chk("cur_floor_at_door", 32'(cur_floor), pos / SEG + 1);
                chk("door_aligned", pos % SEG, 0);
            end
            door_prev = door_open;
            if (pending == 3'b000 && !door_open && !mup && !mdw) begin
                done = 1;
                break;
            end
        end
        call = 3'b000;
        chk("collect_done", 32'(done), 1);
    endtask

    // Expected door sequence for a request set, from the policy's rules:
    // the current floor first, then keep direction while requests lie that
    // way, otherwise nearest request, equal distance goes down.
    task automatic model_order(input logic [2:0] req);
        logic [2:0] s;
        int go, tgt, da, db;
        s = req;
        exp_q.delete();
        if (s[mdl_floor-1]) begin
            exp_q.push_back(mdl_floor);
            s[mdl_floor-1] = 1'b0;
        end
        while (s != 3'b000) begin
            da = 99;
            db = 99;
            for (int f = 1; f <= 3; f++) begin
                if (s[f-1]) begin
                    if (f > mdl_floor && f - mdl_floor < da) da = f - mdl_floor;
                    if (f < mdl_floor && mdl_floor - f < db) db = mdl_floor - f;
                end
            end
            if (mdl_dir == 1 && da < 99) go = 1;
            else if (mdl_dir == 2 && db < 99) go = 2;
            else go = (db <= da) ? 2 : 1;
            tgt = (go == 1) ? mdl_floor + da : mdl_floor - db;
            exp_q.push_back(tgt);
            s[tgt-1] = 1'b0;
            mdl_floor = tgt;
            mdl_dir   = go;
        end
    endtask

    task automatic compare_served(input string tag);
        int n;
        chk({tag, "_count"}, served_q.size(), exp_q.size());
        n = (served_q.size() < exp_q.size()) ? served_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_floor"}, served_q[i], exp_q[i]);
        chk({tag, "_pending_empty"}, 32'(pending), 0);
    endtask

    initial begin
        int n;
        logic [2:0] s;

        // 1: overweight blocks departure, then a trip 1 -> 2 with door timing.
        do_reset(3'b001, 1'b1, 3'b010);
        tick();
        chk("t1_cur_floor", 32'(cur_floor), 1);
        chk("t1_pending", 32'(pending), 3'b010);
        tick(); tick(); tick();
        chk("t1_overweight_hold", 32'({mup, mdw}), 0);
        overweight = 1'b0;
        call       = 3'b000;
        tick();
        chk("t1_mup", 32'(mup), 1);
        floor_sns = 3'b000;
        tick();
        floor_sns = 3'b010;
        tick();
        chk("t1_stop", 32'({mup, mdw, door_open}), 3'b001);
        chk("t1_cur_floor2", 32'(cur_floor), 2);
        chk("t1_pending_clear", 32'(pending), 0);
        n = 0;
        while (door_open && n < 20) begin
            n++;
            tick();
        end
        chk("t1_door_cycles", n, 8);

        // 2: homing from unknown position.
        do_reset(3'b000, 1'b0, 3'b000);
        tick();
        chk("t2_homing_mdw", 32'(mdw), 1);
        floor_sns = 3'b001;
        tick();
        chk("t2_home_mdw_off", 32'(mdw), 0);
        chk("t2_home_floor", 32'(cur_floor), 1);

        // 3: calls 1 and 2, then 3 while moving: doors at 1, 2, 3.
        pos      = 0;
        plant_en = 1;
        call = 3'b011;
        tick();
        call = 3'b000;
        collect(3'b100);
        exp_q.delete();
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        compare_served("t3");
        plant_en = 0;

        // 4: illegal sensor sequence while moving 1 -> 2.
        do_reset(3'b001, 1'b0, 3'b000);
        tick();
        call = 3'b010;
        tick();
        call = 3'b000;
        wait_mup();
        floor_sns = 3'b000;
        tick();
        floor_sns = 3'b100;
        tick();
        chk("t4_motor_off", 32'({mup, mdw, door_open}), 0);
        chk("t4_fault", 32'({fault, fault_code}), 3'b110);
        call = 3'b111;
        tick(); tick(); tick();
        call = 3'b000;
        chk("t4_calls_ignored", 32'(pending), 0);
        chk("t4_fault_sticky", 32'({fault, fault_code, door_open}), 4'b1100);

        // 5: two sensors high in IDLE, then restart at floor 3.
        do_reset(3'b001, 1'b0, 3'b000);
        tick(); tick();
        floor_sns = 3'b011;
        tick();
        chk("t5_fault_multi", 32'({fault, fault_code}), 3'b101);
        do_reset(3'b100, 1'b0, 3'b000);
        tick();
        chk("t5_cur_floor3", 32'(cur_floor), 3);
        chk("t5_fault_clear", 32'(fault), 0);

        // 6: reset mid-motion drops the motor without a clock edge.
        do_reset(3'b001, 1'b0, 3'b000);
        tick();
        call = 3'b100;
        tick();
        call = 3'b000;
        wait_mup();
        reset = 1'b1;
        #2;
        chk("t6_async_reset", 32'({mup, mdw, door_open, cur_floor}), 0);

        // 7: motion with no further sensor edge.
        do_reset(3'b001, 1'b0, 3'b000);
        tick();
        call = 3'b100;
        tick();
        call = 3'b000;
        wait_mup();
        floor_sns = 3'b000;
        n = 0;
        while (!fault && n < 200) begin
            tick();
            n++;
        end
`ifdef ELEV_TRAVEL_TIMEOUT_EN
        chk("t7_timeout_cycles", n, 64);
        chk("t7_timeout_code", 32'({fault, fault_code, mup}), 4'b1110);
`else
        chk("t7_no_timeout", 32'({fault, mup}), 2'b01);
`endif

        // 8: random call sets against the reference floor order.
        pos      = 0;
        plant_en = 1;
        do_reset(3'b001, 1'b0, 3'b000);
        tick();
        mdl_floor = 1;
        mdl_dir   = 0;
        for (int t = 0; t < 25; t++) begin
            s = 3'($urandom_range(1, 7));
            model_order(s);
            call = s;
            tick();
            call = 3'b000;
            collect(3'b000);
            compare_served("rnd");
        end
        chk("rnd_no_fault", 32'(fault), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Sequencing controller for the 3-floor elevator datapath.
- Latches cabin/hall calls, picks the next target floor with a collective direction-keeping policy, and drives the motor up/down and door commands.
- Supervises the one-hot floor sensors and the overweight sensor, and locks into a safe fault state on inconsistent sensors.
- Sits between raw inputs (calls, floor sensors, overweight) and the existing motor/7-segment/LED output stage.

Parameters:
- N_FLOORS, 3, number of floors; also the width of the call and sensor vectors.
- DOOR_CYCLES, 8, clk cycles the door stays open at a served floor.
- TIMEOUT_CYCLES, 64, maximum clk cycles of motion without a new sensor edge (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- call  in  N_FLOORS  call buttons, bit i = floor i+1; level, any pulse width >= 1 clk.
- floor_sns  in  N_FLOORS  floor sensors, bit i high while cabin is at floor i+1.
- overweight  in  1  overweight sensor; high inhibits departure.
- mup  out  1  motor up command, registered.
- mdw  out  1  motor down command, registered.
- door_open  out  1  door command, registered.
- cur_floor  out  2  last valid floor, 1..3; 0 = unknown.
- pending  out  N_FLOORS  latched request vector.
- fault  out  1  sticky fault flag.
- fault_code  out  2  0 none, 1 multiple sensors, 2 illegal sensor sequence, 3 travel timeout.

Behaviour:
- Reset values: clk/reset fixed as above; all outputs 0; state INIT; pending and last_dir cleared.
- Request latch: call[i]=1 sets pending[i] on the next edge. pending[i] clears on entry to DOOR at floor i+1. Calls are ignored in FAULT.
- Motor commands: mup and mdw are never both 1. Both are 0 whenever door_open=1.

States:
- INIT (1 cycle):
  - exactly one sensor high -> latch cur_floor, go to IDLE.
  - no sensor high -> HOMING.
  - more than one sensor high -> FAULT, code 1.
- HOMING: mdw=1. First sensor edge -> latch cur_floor, mdw=0 next cycle, IDLE. Calls are latched but not served until IDLE.
- IDLE:
  - pending[cur] set -> DOOR.
  - otherwise, if any request: keep last_dir if requests exist in that direction; else go to the nearest request, tie -> down.
  - Leads to MOVE_UP or MOVE_DOWN. Departure blocked while overweight=1.
- MOVE_UP / MOVE_DOWN: motor asserted. On rising sensor edge at floor k:
  - k = cur±1 in the travel direction -> cur_floor=k.
  - pending[k] set -> motor off next cycle, DOOR.
  - otherwise keep moving.
- DOOR: door_open=1 for DOOR_CYCLES. The counter restarts while overweight=1. At expiry -> IDLE. A new call for the current floor during DOOR restarts the counter and does not latch.

Fault conditions (any state except INIT):
- More than one sensor high -> code 1.
- Sensor edge not equal to cur±1 in the travel direction, or any sensor edge in IDLE/DOOR at a floor other than cur -> code 2.
- On fault: within 1 cycle mup=mdw=door_open=0, pending cleared. FAULT is exited only by reset.

Other rules:
- Precedence on simultaneous events: fault > stop/serve > new call latch.
- Reset mid-motion: outputs drop asynchronously; restart from INIT.
- Sensor edges are derived from a 1-cycle registered copy of floor_sns.

Optional Feature:
- Macro ELEV_TRAVEL_TIMEOUT_EN.
- Defined: a counter runs in MOVE_*/HOMING and restarts on every sensor edge. Reaching TIMEOUT_CYCLES -> FAULT, code 3.
- Undefined: no counter, code 3 never produced, TIMEOUT_CYCLES unused.

Decomposition:
- Shared package elevador_pkg: state enum (INIT, HOMING, IDLE, MOVE_UP, MOVE_DOWN, DOOR, FAULT), fault code constants, direction type, N_FLOORS default.
- One sub-module, elev_target_select: combinational next-direction pick from pending, cur_floor and last_dir.
- Request latch and FSM stay in the top module.

Test Plan:
- Reset at floor_sns=001, overweight=1, call=010 -> IDLE, no motor. Drop overweight -> mup=1; floor_sns=010 -> mup=0, door_open=1 for 8 cycles, pending=000, cur_floor=2.
- Reset with floor_sns=000 -> mdw=1. floor_sns=001 -> mdw=0, cur_floor=1, IDLE.
- At floor 1, call 011 then 100 while moving -> stops at 2 (door), then continues to 3 (door), pending=000.
- Moving 1->2 and floor_sns jumps 001->000->100 -> FAULT code 2, mup=mdw=0 within 1 cycle. Calls ignored until reset.
- In IDLE at floor 1, floor_sns=011 -> FAULT code 1; reset with floor_sns=100 -> cur_floor=3.
- Macro defined, TIMEOUT_CYCLES=64, moving with no sensor edge -> fault_code=3 at cycle 64. Undefined -> motion continues indefinitely.
